// File: rtl/sdio_master_mc_if.sv
// Register-side request/response and per-channel serial lines of sdio_master_mc.
// The master modport is the bridge's own view; slave is the requester/frontend view.
interface sdio_master_mc_if #(
   parameter int AW  = 8,
   parameter int DW  = 32,
   parameter int CHW = 1
);
   localparam int NCH = 2**CHW;

   logic [CHW+AW-1:0] reg_addr;
   logic [DW-1:0]     reg_writedata;
   logic              reg_rd_sdio;
   logic              reg_wr_sdio;
   logic              reg_ready_sdio;
   logic [DW-1:0]     reg_readdata_sdio;
   logic              reg_err_sdio;
   logic [NCH-1:0]    sdio_miso;
   logic [NCH-1:0]    sdio_mosi;
   logic              sdio_sck;

   modport master (
      input  reg_addr, reg_writedata, reg_rd_sdio, reg_wr_sdio, sdio_miso,
      output reg_ready_sdio, reg_readdata_sdio, reg_err_sdio, sdio_mosi, sdio_sck
   );

   modport slave (
      output reg_addr, reg_writedata, reg_rd_sdio, reg_wr_sdio, sdio_miso,
      input  reg_ready_sdio, reg_readdata_sdio, reg_err_sdio, sdio_mosi, sdio_sck
   );
endinterface

// File: rtl/sdio_master_mc.sv
// Serial register-access master: bridges register read/write requests to NCH serial slaves.
// Optional even parity on command frame and read data when SDIO_PARITY_EN is defined.
module sdio_master_mc #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int CHW     = 1,
   parameter int CLK_DIV = 5,
   parameter int TIMEOUT = 220
) (
   input  logic             clk_2,
   input  logic             rst_n,
   sdio_master_mc_if.master bus
);

   localparam int NCH  = 2**CHW;
`ifdef SDIO_PARITY_EN
   localparam int PW   = 1;
`else
   localparam int PW   = 0;
`endif
   localparam int FL   = 2 + AW + DW + PW;
   localparam int RL   = DW + PW;
   localparam int CNTW = $clog2(FL + 1);
   localparam int DIVW = $clog2(CLK_DIV);
   localparam int TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CMD, HUNT, RDATA, DONE} state_t;

   state_t            state_q, state_d;
   logic [DIVW-1:0]   div_q;
   logic              sck_q, sck_d1, sck_d2;
   logic              req_q;
   logic              rw_q;
   logic [CHW-1:0]    ch_q;
   logic [FL-1:0]     tx_q;
   logic [RL-2:0]     rx_q;
   logic [CNTW-1:0]   bit_cnt;
   logic [TW-1:0]     t_cnt;
   logic [DW-1:0]     rdata_q;
   logic              err_q;

   logic              req, req_rise, act_req;
   logic              rise_stb, fall_stb, miso_sel;
   logic [FL-1:0]     frame;
   logic              rw_in;
   logic [DW-1:0]     wd_in;
   logic [RL-1:0]     rx_nxt;
   logic              rd_err;
   logic [NCH-1:0]    mosi;
   logic              load, tx_shift, rx_shift, cnt_inc, cnt_clr, t_inc;
   logic              fin_ack, fin_to, fin_rd;

   assign req      = bus.reg_rd_sdio | bus.reg_wr_sdio;
   assign req_rise = req & ~req_q;
   assign act_req  = rw_q ? bus.reg_wr_sdio : bus.reg_rd_sdio;
   assign rise_stb = sck_d1 & ~sck_d2;
   assign fall_stb = ~sck_d1 & sck_d2;
   assign miso_sel = bus.sdio_miso[ch_q];
   assign rx_nxt   = {rx_q, miso_sel};

   // Write takes priority when both requests rise together
   assign rw_in = bus.reg_wr_sdio;
   assign wd_in = bus.reg_wr_sdio ? bus.reg_writedata : '0;

`ifdef SDIO_PARITY_EN
   assign frame  = {1'b1, rw_in, bus.reg_addr[AW-1:0], wd_in,
                    ^{rw_in, bus.reg_addr[AW-1:0], wd_in}};
   assign rd_err = ^rx_nxt;
`else
   assign frame  = {1'b1, rw_in, bus.reg_addr[AW-1:0], wd_in};
   assign rd_err = 1'b0;
`endif

   // Free-running sck plus the twice-registered copy used for edge strobes
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         sck_q  <= 1'b0;
         sck_d1 <= 1'b0;
         sck_d2 <= 1'b0;
         req_q  <= 1'b0;
      end else begin
         if (div_q == DIVW'(CLK_DIV - 1)) begin
            div_q <= '0;
            sck_q <= ~sck_q;
         end else begin
            div_q <= div_q + 1'b1;
         end
         sck_d1 <= sck_q;
         sck_d2 <= sck_d1;
         req_q  <= req;
      end
   end

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      tx_shift = 1'b0;
      rx_shift = 1'b0;
      cnt_inc  = 1'b0;
      cnt_clr  = 1'b0;
      t_inc    = 1'b0;
      fin_ack  = 1'b0;
      fin_to   = 1'b0;
      fin_rd   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_rise) begin
               state_d = CMD;
               load    = 1'b1;
            end
         end
         CMD: begin
            if (!act_req) begin
               state_d = IDLE;
            end else if (rise_stb) begin
               if (bit_cnt == CNTW'(FL - 1)) begin
                  state_d = HUNT;
                  cnt_clr = 1'b1;
               end else begin
                  tx_shift = 1'b1;
                  cnt_inc  = 1'b1;
               end
            end
         end
         HUNT: begin
            if (!act_req) begin
               state_d = IDLE;
            end else if (fall_stb) begin
               if (miso_sel) begin
                  if (rw_q) begin
                     state_d = DONE;
                     fin_ack = 1'b1;
                  end else begin
                     state_d = RDATA;
                  end
               end else if (t_cnt == TW'(TIMEOUT - 1)) begin
                  state_d = DONE;
                  fin_to  = 1'b1;
               end else begin
                  t_inc = 1'b1;
               end
            end
         end
         RDATA: begin
            if (!act_req) begin
               state_d = IDLE;
            end else if (fall_stb) begin
               rx_shift = 1'b1;
               if (bit_cnt == CNTW'(RL - 1)) begin
                  state_d = DONE;
                  fin_rd  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         DONE: begin
            if (!act_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         rw_q    <= 1'b0;
         ch_q    <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_cnt <= '0;
         t_cnt   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (load) begin
            rw_q    <= rw_in;
            ch_q    <= bus.reg_addr[CHW+AW-1:AW];
            tx_q    <= frame;
            rx_q    <= '0;
            bit_cnt <= '0;
            t_cnt   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
         if (tx_shift) tx_q <= {tx_q[FL-2:0], 1'b0};
         if (cnt_clr)      bit_cnt <= '0;
         else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;
         if (t_inc && (t_cnt != TW'(TIMEOUT))) t_cnt <= t_cnt + 1'b1;
         if (rx_shift) rx_q <= rx_nxt[RL-2:0];
         if (fin_ack) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
         if (fin_to) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
         // Last received bit is folded in via rx_nxt, not yet in rx_q
         if (fin_rd) begin
            rdata_q <= rx_nxt[RL-1:PW];
            err_q   <= rd_err;
         end
      end
   end

   always_comb begin
      mosi = '0;
      if (state_q == CMD) mosi[ch_q] = tx_q[FL-1];
   end

   assign bus.sdio_mosi         = mosi;
   assign bus.sdio_sck          = sck_q;
   assign bus.reg_ready_sdio    = (state_q == DONE);
   assign bus.reg_readdata_sdio = rdata_q;
   assign bus.reg_err_sdio      = err_q;

endmodule

// File: tb/tb_sdio_master_mc.sv
// Directed bench for sdio_master_mc: table of register transactions plus abort/reset sequences.
// Honours SDIO_PARITY_EN in the frame model and the parity vectors.
module tb_sdio_master_mc;

   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int CHW = 1;
`ifdef SDIO_PARITY_EN
   localparam int PW  = 1;
`else
   localparam int PW  = 0;
`endif
   localparam int FL  = 2 + AW + DW + PW;

   typedef struct {
      logic        ch;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        rd;
      logic        wr;
      int          delay;
      bit          silent;
      logic [31:0] sdata;
      logic        bad_par;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic clk_2 = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk_2 = ~clk_2;

   sdio_master_mc_if #(.AW(AW), .DW(DW), .CHW(CHW)) bus ();

   sdio_master_mc #(.AW(AW), .DW(DW), .CHW(CHW), .CLK_DIV(5), .TIMEOUT(220)) dut (
      .clk_2 (clk_2),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic bound_fail(input string name);
      n_total++;
      $display("FAIL %s: got no event, expected one within bound", name);
   endtask

   // Returns at the first clk_2 falling edge after sck reaches the requested level
   task automatic wait_sck(input logic rising);
      logic prev;
      prev = bus.sdio_sck;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk_2);
         if (bus.sdio_sck === rising && prev === ~rising) return;
         prev = bus.sdio_sck;
      end
      bound_fail("sck_edge");
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_2);
         if (bus.reg_ready_sdio === 1'b1) return;
      end
      bound_fail("ready_wait");
   endtask

   function automatic logic [63:0] exp_frame(input vec_t v);
      logic [FL-1:0] fr;
      logic [31:0]   d;
      d = v.wr ? v.wdata : 32'h0;
`ifdef SDIO_PARITY_EN
      fr = {1'b1, v.wr, v.addr, d, ^{v.wr, v.addr, d}};
`else
      fr = {1'b1, v.wr, v.addr, d};
`endif
      return 64'(fr);
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      logic [63:0] got;
      logic        other;
      got   = '0;
      other = 1'b0;
      wait_sck(1'b0);
      bus.reg_addr      = {v.ch, v.addr};
      bus.reg_writedata = v.wdata;
      bus.reg_rd_sdio   = v.rd;
      bus.reg_wr_sdio   = v.wr;
      for (int k = 0; k < FL; k++) begin
         wait_sck(1'b1);
         got   = {got[62:0], bus.sdio_mosi[v.ch]};
         other = other | bus.sdio_mosi[~v.ch];
      end
      check({tag, ".frame"}, got, exp_frame(v));
      check({tag, ".other_mosi"}, 64'(other), 64'h0);
      if (v.silent) begin
         for (int i = 1; i <= 220; i++) begin
            wait_sck(1'b0);
            if (i == 1) check({tag, ".mosi_idle"}, 64'(bus.sdio_mosi), 64'h0);
         end
         check({tag, ".ready_pre_timeout"}, 64'(bus.reg_ready_sdio), 64'h0);
         @(negedge clk_2);
         @(negedge clk_2);
      end else begin
         for (int i = 1; i <= v.delay; i++) begin
            wait_sck(1'b1);
            if (i == 1) check({tag, ".mosi_idle"}, 64'(bus.sdio_mosi), 64'h0);
         end
         bus.sdio_miso[v.ch] = 1'b1;
         if (!v.wr) begin
            for (int i = 0; i < DW; i++) begin
               wait_sck(1'b1);
               bus.sdio_miso[v.ch] = v.sdata[DW-1-i];
            end
`ifdef SDIO_PARITY_EN
            wait_sck(1'b1);
            bus.sdio_miso[v.ch] = (^v.sdata) ^ v.bad_par;
`endif
         end
         wait_sck(1'b1);
         bus.sdio_miso[v.ch] = 1'b0;
         wait_ready();
      end
      check({tag, ".ready"}, 64'(bus.reg_ready_sdio), 64'h1);
      check({tag, ".err"}, 64'(bus.reg_err_sdio), 64'(v.exp_err));
      check({tag, ".rdata"}, 64'(bus.reg_readdata_sdio), 64'(v.exp_rdata));
      repeat (3) @(negedge clk_2);
      check({tag, ".ready_held"}, 64'(bus.reg_ready_sdio), 64'h1);
      check({tag, ".rdata_held"}, 64'(bus.reg_readdata_sdio), 64'(v.exp_rdata));
      bus.reg_rd_sdio = 1'b0;
      bus.reg_wr_sdio = 1'b0;
      @(negedge clk_2);
      check({tag, ".ready_drop"}, 64'(bus.reg_ready_sdio), 64'h0);
   endtask

   initial begin
      int   cnt;
      logic p;
      logic seen;

      //          ch    addr   wdata         rd    wr    dly silent sdata         badp  exp_rdata     err
      vecs.push_back(vec_t'{1'b0, 8'h12, 32'hDEADBEEF, 1'b0, 1'b1, 3, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
      vecs.push_back(vec_t'{1'b1, 8'hA5, 32'h55555555, 1'b1, 1'b0, 2, 1'b0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0});
      vecs.push_back(vec_t'{1'b0, 8'h3C, 32'h0,        1'b1, 1'b0, 0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1});
      vecs.push_back(vec_t'{1'b1, 8'h01, 32'h12345678, 1'b1, 1'b1, 1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
      vecs.push_back(vec_t'{1'b0, 8'h7E, 32'h0,        1'b1, 1'b0, 5, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'hFF, 32'h00000000, 1'b0, 1'b1, 1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
`ifdef SDIO_PARITY_EN
      vecs.push_back(vec_t'{1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 2, 1'b0, 32'h00000001, 1'b1, 32'h00000001, 1'b1});
`endif

      bus.reg_addr      = '0;
      bus.reg_writedata = '0;
      bus.reg_rd_sdio   = 1'b0;
      bus.reg_wr_sdio   = 1'b0;
      bus.sdio_miso     = '0;

      repeat (3) @(negedge clk_2);
      check("rst.ready", 64'(bus.reg_ready_sdio), 64'h0);
      check("rst.err", 64'(bus.reg_err_sdio), 64'h0);
      check("rst.rdata", 64'(bus.reg_readdata_sdio), 64'h0);
      check("rst.mosi", 64'(bus.sdio_mosi), 64'h0);
      check("rst.sck", 64'(bus.sdio_sck), 64'h0);
      rst_n = 1'b1;

      // sck: first rise CLK_DIV cycles after reset, then period 2*CLK_DIV
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_2);
         cnt++;
         if (bus.sdio_sck === 1'b1) break;
      end
      check("sck.first_rise", 64'(cnt), 64'd5);
      cnt = 0;
      p   = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_2);
         cnt++;
         if (bus.sdio_sck === 1'b1 && p === 1'b0) break;
         p = bus.sdio_sck;
      end
      check("sck.period", 64'(cnt), 64'd10);

      foreach (vecs[i]) run_txn(vecs[i], $sformatf("v%0d", i));

      // Abort: write dropped while frame bit 10 (wdata MSB = 1) is on mosi
      wait_sck(1'b0);
      bus.reg_addr      = {1'b0, 8'h55};
      bus.reg_writedata = 32'h80000000;
      bus.reg_wr_sdio   = 1'b1;
      for (int k = 0; k <= 10; k++) wait_sck(1'b1);
      check("abort.bit10", 64'(bus.sdio_mosi), 64'h1);
      bus.reg_wr_sdio = 1'b0;
      @(negedge clk_2);
      check("abort.mosi_zero", 64'(bus.sdio_mosi), 64'h0);
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_2);
         seen = seen | bus.reg_ready_sdio | (|bus.sdio_mosi);
      end
      check("abort.no_ready_no_mosi", 64'(seen), 64'h0);
      run_txn(vec_t'{1'b0, 8'h33, 32'hA5A5C3C3, 1'b0, 1'b1, 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}, "post_abort");

      // Reset pulse in the middle of read data reception
      wait_sck(1'b0);
      bus.reg_addr    = {1'b1, 8'h22};
      bus.reg_rd_sdio = 1'b1;
      for (int k = 0; k < FL; k++) wait_sck(1'b1);
      wait_sck(1'b1);
      bus.sdio_miso[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_sck(1'b1);
         bus.sdio_miso[1] = ~bus.sdio_miso[1];
      end
      wait_sck(1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid.sck", 64'(bus.sdio_sck), 64'h0);
      check("rst_mid.mosi", 64'(bus.sdio_mosi), 64'h0);
      check("rst_mid.ready", 64'(bus.reg_ready_sdio), 64'h0);
      check("rst_mid.err", 64'(bus.reg_err_sdio), 64'h0);
      check("rst_mid.rdata", 64'(bus.reg_readdata_sdio), 64'h0);
      bus.reg_rd_sdio = 1'b0;
      bus.sdio_miso   = '0;
      repeat (3) @(negedge clk_2);
      rst_n = 1'b1;
      run_txn(vec_t'{1'b1, 8'h22, 32'h0, 1'b1, 1'b0, 1, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0}, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sdio_master_mc.md
Name: sdio_master_mc

Overview:
- Parametrised successor serial register-access master: bridges AXI-side register read/write requests to NCH serial slaves over a shared sck and per-channel mosi/miso.
- Adds over the previous generation:
  - configurable address, data and divider widths;
  - an explicit FSM with response start-bit detection;
  - error reporting on timeout;
  - request abort handling.
- Sits between the AXI register decoder and the FPGA-to-frontend serial links.

Parameters:
- AW, 8, slave register address width.
- DW, 32, register data width.
- CHW, 1, channel-select width; NCH = 2**CHW channels.
- CLK_DIV, 5, clk_2 cycles per sck half-period (legal range 2..255).
- TIMEOUT, 220, sck periods to wait for the response start bit before error.

Ports:
- clk_2  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- reg_addr  in  CHW+AW  [CHW+AW-1:AW] is the channel, [AW-1:0] is the slave address.
- reg_writedata  in  DW  write data.
- reg_rd_sdio  in  1  read request, level, held until ready.
- reg_wr_sdio  in  1  write request, level, held until ready.
- reg_ready_sdio  out  1  transaction complete.
- reg_readdata_sdio  out  DW  read data, valid with ready.
- reg_err_sdio  out  1  timeout/parity error, valid with ready.
- sdio_miso  in  NCH  per-channel slave data.
- sdio_mosi  out  NCH  per-channel master data; 0 on unselected channels.
- sdio_sck  out  1  shared serial clock, free-running.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; divider 0; FSM IDLE; shift registers 0.
- sck generation:
  - Divider counts 0..CLK_DIV-1; sck toggles when the counter wraps.
  - sck period = 2*CLK_DIV clk_2 cycles; runs continuously after reset.
- Edge strobes: rise/fall strobes are derived from sck registered twice (2-cycle lag).
  - mosi shifts on the rise strobe.
  - miso of the latched channel is sampled on the fall strobe.
- Request capture: rising edge of (reg_rd_sdio|reg_wr_sdio) in IDLE latches addr, channel, data and rw.
  - Write wins if both requests rise in the same cycle.
  - Requests already high coming out of reset count as a rising edge.
- Frame: {1'b1, rw(1=write), addr[AW-1:0], wdata[DW-1:0] or 0 for read}, MSB first, L = 2+AW+DW bits.
  - The first bit appears on mosi at capture; each subsequent bit appears at the next rise strobe.
- FSM states:
  - IDLE -> CMD on capture.
  - CMD -> HUNT after L rise strobes (mosi returns to 0).
  - HUNT: sample miso on each fall strobe.
    - First 1 -> RDATA (read) or DONE (write ack).
    - After TIMEOUT fall strobes with no 1 -> DONE with err=1.
  - RDATA: shift DW bits MSB first on fall strobes, then -> DONE.
  - DONE: reg_ready_sdio=1, readdata/err held stable.
    - Return to IDLE one cycle after the active request drops.
    - ready deasserts in that same cycle.
- Outputs on completion:
  - Write: readdata=0.
  - Timeout: readdata=0, err=1.
  - Otherwise: err=0.
- Abort: request dropped in CMD/HUNT/RDATA -> IDLE next cycle; mosi=0; no ready pulse; partial rx discarded.
- Request changes in the middle of a transaction are ignored; latched values are used.
- Timeout counter width is sized for TIMEOUT; it saturates and does not wrap.

Optional Feature:
- Macro SDIO_PARITY_EN.
- Defined:
  - One even-parity bit, covering rw, addr and data, is appended to the command frame (L+1 bits).
  - On reads, one parity bit follows the DW data bits; the slave's parity covers the data.
  - Mismatch -> DONE with err=1; readdata is still presented.
  - Write ack is unchanged.
- Undefined: no parity bits anywhere; err is set only by timeout.

Test Plan:
- Write ch0, addr 0x12, data 0xDEADBEEF; slave ack at 3rd sck after the frame:
  - mosi ch0 = 1,1,0x12,0xDEADBEEF (42 bits), ch1 mosi=0;
  - ready=1, err=0, readdata=0.
- Read ch1, addr 0xA5; slave returns start bit then 0x0BADF00D:
  - frame has rw=0 and 32 zero data bits;
  - readdata=0x0BADF00D, err=0, ready held until reg_rd_sdio drops, then 0 the next cycle.
- Read with a silent slave:
  - ready asserts after exactly 220 fall strobes following the frame, err=1, readdata=0.
- Rd and wr rising together, addr 0x01:
  - the frame carries rw=1 and the write data.
- Request dropped at frame bit 10:
  - FSM IDLE next cycle, mosi=0, ready never asserts;
  - a subsequent write completes normally.
- rst_n pulsed low during RDATA:
  - all outputs 0 immediately, sck=0;
  - after release, a new read completes correctly.
- With SDIO_PARITY_EN: read data 0x00000001 with wrong parity bit 0 -> err=1, readdata=0x00000001.
